// File: rtl/dmi_access_filter.sv
// DMI request filter between the core-side CDC port and the debug module.
// Optional audit outputs are enabled with DMI_FILTER_AUDIT_EN.
module dmi_access_filter #(
  parameter logic [6:0]  ProtLo        = 7'h10,
  parameter logic [6:0]  ProtHi        = 7'h7F,
  parameter int unsigned TimeoutCycles = 1024,
  parameter int unsigned CntWidth      = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                unlock_i,
  input  logic [40:0]         req_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  output logic [33:0]         resp_o,
  output logic                resp_valid_o,
  input  logic                resp_ready_i,
  output logic [40:0]         dm_req_o,
  output logic                dm_req_valid_o,
  input  logic                dm_req_ready_i,
  input  logic [33:0]         dm_resp_i,
  input  logic                dm_resp_valid_i,
  output logic                dm_resp_ready_o,
`ifdef DMI_FILTER_AUDIT_EN
  output logic [CntWidth-1:0] blocked_cnt_o,
  output logic [6:0]          last_blocked_addr_o,
  output logic [0:0]          blocked_pulse_o
`else
  output logic [CntWidth-1:0] blocked_cnt_o
`endif
);

  localparam int unsigned TmoW =
    (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [TmoW-1:0] TmoLast =
    TmoW'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    WAIT_RESP,
    RESP
  } state_e;

  state_e          state;
  logic [TmoW-1:0] tmo_cnt;

  logic [6:0] addr;
  logic [1:0] op;
  logic       in_win;
  logic       is_rw;
  logic       reject;
  logic       accept;

  assign addr   = req_i[40:34];
  assign op     = req_i[1:0];
  // An inverted window (ProtLo > ProtHi) is empty by construction.
  assign in_win = (addr >= ProtLo) && (addr <= ProtHi);
  assign is_rw  = (op == 2'd1) || (op == 2'd2);
  assign reject = (op == 2'd3) || (is_rw && in_win && !unlock_i);
  assign accept = req_valid_i && (state == IDLE);

  assign req_ready_o     = (state == IDLE);
  assign dm_resp_ready_o = 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      resp_o         <= '0;
      resp_valid_o   <= 1'b0;
      dm_req_o       <= '0;
      dm_req_valid_o <= 1'b0;
      blocked_cnt_o  <= '0;
      tmo_cnt        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid_i) begin
            unique case (1'b1)
              (op == 2'd0): begin
                resp_o       <= {32'h0, 2'h0};
                resp_valid_o <= 1'b1;
                state        <= RESP;
              end
              reject: begin
                resp_o       <= {32'h0, 2'h2};
                resp_valid_o <= 1'b1;
                state        <= RESP;
                if (blocked_cnt_o != '1) begin
                  blocked_cnt_o <= blocked_cnt_o + CntWidth'(1);
                end
              end
              default: begin
                dm_req_o       <= req_i;
                dm_req_valid_o <= 1'b1;
                state          <= FWD;
              end
            endcase
          end
        end
        FWD: begin
          if (dm_req_ready_i) begin
            dm_req_valid_o <= 1'b0;
            tmo_cnt        <= '0;
            state          <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (dm_resp_valid_i) begin
            resp_o       <= dm_resp_i;
            resp_valid_o <= 1'b1;
            state        <= RESP;
          end else if (TimeoutCycles != 0) begin
            tmo_cnt <= tmo_cnt + TmoW'(1);
            if (tmo_cnt == TmoLast) begin
              resp_o       <= {32'h0, 2'h3};
              resp_valid_o <= 1'b1;
              state        <= RESP;
            end
          end
        end
        RESP: begin
          if (resp_ready_i) begin
            resp_valid_o <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMI_FILTER_AUDIT_EN
  assign blocked_pulse_o = accept && reject;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_blocked_addr_o <= '0;
    end else if (accept && reject) begin
      last_blocked_addr_o <= addr;
    end
  end
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_dmi_access_filter.sv
// Randomised self-checking bench for dmi_access_filter.
// Runs with TimeoutCycles=8 and CntWidth=2 to reach the boundary cases.
module tb_dmi_access_filter;

  localparam logic [6:0] PLO  = 7'h10;
  localparam logic [6:0] PHI  = 7'h7F;
  localparam int         CW   = 2;
  localparam int         CMAX = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          unlock_i;
  logic [40:0]   req_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [33:0]   resp_o;
  logic          resp_valid_o;
  logic          resp_ready_i;
  logic [40:0]   dm_req_o;
  logic          dm_req_valid_o;
  logic          dm_req_ready_i;
  logic [33:0]   dm_resp_i;
  logic          dm_resp_valid_i;
  logic          dm_resp_ready_o;
  logic [CW-1:0] blocked_cnt_o;
`ifdef DMI_FILTER_AUDIT_EN
  logic [6:0]    last_blocked_addr_o;
  logic [0:0]    blocked_pulse_o;
`endif

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  logic [6:0] exp_last = '0;

  always #5 clk_i = ~clk_i;

  dmi_access_filter #(
    .ProtLo(PLO),
    .ProtHi(PHI),
    .TimeoutCycles(8),
    .CntWidth(CW)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .unlock_i(unlock_i),
    .req_i(req_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .resp_o(resp_o),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i),
    .dm_req_o(dm_req_o),
    .dm_req_valid_o(dm_req_valid_o),
    .dm_req_ready_i(dm_req_ready_i),
    .dm_resp_i(dm_resp_i),
    .dm_resp_valid_i(dm_resp_valid_i),
    .dm_resp_ready_o(dm_resp_ready_o),
`ifdef DMI_FILTER_AUDIT_EN
    .blocked_cnt_o(blocked_cnt_o),
    .last_blocked_addr_o(last_blocked_addr_o),
    .blocked_pulse_o(blocked_pulse_o)
`else
    .blocked_cnt_o(blocked_cnt_o)
`endif
  );

  // Reference: 0 = local ok (nop), 1 = rejected, 2 = forwarded.
  function automatic int classify(input logic [6:0] a,
                                  input logic [1:0] op,
                                  input logic unl);
    if (op == 2'd0) return 0;
    if (op == 2'd3) return 1;
    if (int'(a) >= int'(PLO) && int'(a) <= int'(PHI) && !unl) return 1;
    return 2;
  endfunction

  function automatic int sat_inc(input int c);
    return (c >= CMAX) ? CMAX : c + 1;
  endfunction

  // Runs one request through the DUT acting as requester and debug module.
  // rlat: cycles of dm_req_valid before ready; dlat: WAIT_RESP cycles
  // before the DM answers (-1 never); hold: RESP cycles before consume.
  task automatic txn(
    input  logic [6:0]  a,
    input  logic [31:0] d,
    input  logic [1:0]  op,
    input  logic        unl,
    input  int          rlat,
    input  int          dlat,
    input  logic [33:0] dresp,
    input  int          hold,
    input  bit          drop_unl,
    output bit          rdy,
    output bit          pulse,
    output int          fwd_lat,
    output logic [40:0] fwd_req,
    output int          resp_lat,
    output logic [33:0] resp_val,
    output bit          stable,
    output bit          rdy_in_resp,
    output bit          req_err
  );
    int k, vcnt, wcnt, hcnt;
    bit pend, inw, done, hs;
    @(negedge clk_i);
    resp_ready_i = 1'b0;
    req_i        = {a, d, op};
    req_valid_i  = 1'b1;
    unlock_i     = unl;
    #1;
    rdy = req_ready_o;
`ifdef DMI_FILTER_AUDIT_EN
    pulse = blocked_pulse_o[0];
`else
    pulse = 1'b0;
`endif
    @(posedge clk_i);
    k = 0; vcnt = 0; wcnt = 0; hcnt = 0;
    pend = 0; inw = 0; done = 0; hs = 0;
    fwd_lat = -1; resp_lat = -1;
    fwd_req = '0; resp_val = '0;
    stable = 1; rdy_in_resp = 0; req_err = 0;
    while (!done && k < 100) begin
      @(negedge clk_i);
      k++;
      req_valid_i     = 1'b0;
      dm_req_ready_i  = 1'b0;
      dm_resp_valid_i = 1'b0;
      resp_ready_i    = 1'b0;
      if (pend) begin inw = 1; pend = 0; end
      if (inw && drop_unl) unlock_i = 1'b0;
      if (fwd_lat >= 0 && !hs && !dm_req_valid_o) req_err = 1;
      if (dm_req_valid_o && hs) req_err = 1;
      if (dm_req_valid_o && !hs) begin
        if (fwd_lat < 0) begin
          fwd_lat = k;
          fwd_req = dm_req_o;
        end else if (dm_req_o !== fwd_req) begin
          req_err = 1;
        end
        if (vcnt == rlat) begin
          dm_req_ready_i = 1'b1;
          pend = 1;
          hs = 1;
        end else begin
          vcnt++;
        end
      end
      if (inw) begin
        if (dlat >= 0 && wcnt == dlat) begin
          dm_resp_valid_i = 1'b1;
          dm_resp_i = dresp;
          inw = 0;
        end
        wcnt++;
      end
      if (resp_valid_o) begin
        if (resp_lat < 0) begin
          resp_lat = k;
          resp_val = resp_o;
        end else if (resp_o !== resp_val) begin
          stable = 0;
        end
        if (req_ready_o) rdy_in_resp = 1;
        if (hcnt == hold) begin
          resp_ready_i = 1'b1;
          done = 1;
        end else begin
          hcnt++;
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready_o);
    end
    checks++;
    if (resp_valid_o !== 1'b0 || resp_o !== 34'h0) begin
      errors++;
      $display("FAIL reset_resp: got v=%b d=%h want v=0 d=0",
               resp_valid_o, resp_o);
    end
    checks++;
    if (dm_req_valid_o !== 1'b0 || dm_req_o !== 41'h0) begin
      errors++;
      $display("FAIL reset_dm_req: got v=%b d=%h want v=0 d=0",
               dm_req_valid_o, dm_req_o);
    end
    checks++;
    if (blocked_cnt_o !== '0) begin
      errors++; $display("FAIL reset_cnt: got %0d want 0", blocked_cnt_o);
    end
    checks++;
    if (dm_resp_ready_o !== 1'b1) begin
      errors++; $display("FAIL dm_resp_ready: got %b want 1", dm_resp_ready_o);
    end
`ifdef DMI_FILTER_AUDIT_EN
    checks++;
    if (last_blocked_addr_o !== 7'h0) begin
      errors++;
      $display("FAIL reset_last_addr: got %h want 0", last_blocked_addr_o);
    end
`endif
    rst_ni = 1'b1;
  endtask

  task automatic test_locked_read();
    bit rdy, pl, st, rr, re;
    int fl, rl;
    logic [40:0] fr;
    logic [33:0] rv;
    txn(7'h04, 32'h0, 2'd1, 1'b0, 0, 2, {32'hCAFE0001, 2'h0}, 0, 0,
        rdy, pl, fl, fr, rl, rv, st, rr, re);
    checks++;
    if (fl !== 1 || fr !== {7'h04, 32'h0, 2'd1}) begin
      errors++;
      $display("FAIL locked_read_fwd: got lat=%0d req=%h want lat=1 req=%h",
               fl, fr, {7'h04, 32'h0, 2'd1});
    end
    checks++;
    if (rl !== 5 || rv !== {32'hCAFE0001, 2'h0}) begin
      errors++;
      $display("FAIL locked_read_resp: got lat=%0d d=%h want lat=5 d=%h",
               rl, rv, {32'hCAFE0001, 2'h0});
    end
  endtask

  task automatic test_locked_write();
    bit rdy, pl, st, rr, re;
    int fl, rl;
    logic [40:0] fr;
    logic [33:0] rv;
    txn(7'h20, 32'h55AA55AA, 2'd2, 1'b0, 0, 0, 34'h0, 0, 0,
        rdy, pl, fl, fr, rl, rv, st, rr, re);
    exp_cnt = sat_inc(exp_cnt);
    exp_last = 7'h20;
    checks++;
    if (fl !== -1 || rl !== 1 || rv !== {32'h0, 2'h2}) begin
      errors++;
      $display("FAIL locked_write: got fwd=%0d lat=%0d d=%h want -1 1 %h",
               fl, rl, rv, {32'h0, 2'h2});
    end
    checks++;
    if (int'(blocked_cnt_o) !== exp_cnt) begin
      errors++;
      $display("FAIL locked_write_cnt: got %0d want %0d",
               blocked_cnt_o, exp_cnt);
    end
`ifdef DMI_FILTER_AUDIT_EN
    checks++;
    if (last_blocked_addr_o !== exp_last || pl !== 1'b1) begin
      errors++;
      $display("FAIL locked_write_audit: got addr=%h pulse=%b want %h 1",
               last_blocked_addr_o, pl, exp_last);
    end
`endif
  endtask

  task automatic test_unlock_drop();
    bit rdy, pl, st, rr, re;
    int fl, rl;
    logic [40:0] fr;
    logic [33:0] rv;
    txn(7'h20, 32'h12345678, 2'd2, 1'b1, 1, 3, {32'h0, 2'h0}, 0, 1,
        rdy, pl, fl, fr, rl, rv, st, rr, re);
    checks++;
    if (fl !== 1 || fr !== {7'h20, 32'h12345678, 2'd2} || re) begin
      errors++;
      $display("FAIL unlocked_write_fwd: got lat=%0d req=%h err=%b want 1 %h 0",
               fl, fr, re, {7'h20, 32'h12345678, 2'd2});
    end
    checks++;
    if (rl !== 7 || rv !== 34'h0) begin
      errors++;
      $display("FAIL unlock_drop_resp: got lat=%0d d=%h want lat=7 d=0",
               rl, rv);
    end
  endtask

  task automatic test_timeout();
    bit rdy, pl, st, rr, re;
    int fl, rl;
    logic [40:0] fr;
    logic [33:0] rv;
    bit bad;
    txn(7'h05, 32'h0, 2'd1, 1'b0, 0, -1, 34'h0, 0, 0,
        rdy, pl, fl, fr, rl, rv, st, rr, re);
    checks++;
    if (rl !== 10 || rv !== {32'h0, 2'h3}) begin
      errors++;
      $display("FAIL timeout_resp: got lat=%0d d=%h want lat=10 d=%h",
               rl, rv, {32'h0, 2'h3});
    end
    @(negedge clk_i);
    resp_ready_i = 1'b0;
    dm_resp_i = {32'hDEADBEEF, 2'h0};
    dm_resp_valid_i = 1'b1;
    @(negedge clk_i);
    dm_resp_valid_i = 1'b0;
    bad = 0;
    repeat (3) begin
      if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) bad = 1;
      @(negedge clk_i);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL late_resp_ignored: got v=%b rdy=%b want v=0 rdy=1",
               resp_valid_o, req_ready_o);
    end
  endtask

  task automatic test_back_to_back();
    bit rdy, pl, st, rr, re;
    int fl, rl;
    logic [40:0] fr;
    logic [33:0] rv;
    txn(7'h01, 32'h0, 2'd0, 1'b0, 0, 0, 34'h0, 5, 0,
        rdy, pl, fl, fr, rl, rv, st, rr, re);
    checks++;
    if (rl !== 1 || rv !== 34'h0 || !st || rr) begin
      errors++;
      $display("FAIL hold_resp: got lat=%0d d=%h stable=%b rdy=%b want 1 0 1 0",
               rl, rv, st, rr);
    end
    txn(7'h7F, 32'hA5A5A5A5, 2'd1, 1'b1, 0, 1, {32'h0BADF00D, 2'h0}, 0, 0,
        rdy, pl, fl, fr, rl, rv, st, rr, re);
    checks++;
    if (!rdy || fl !== 1 || rl !== 4 || rv !== {32'h0BADF00D, 2'h0}) begin
      errors++;
      $display("FAIL back_to_back: got rdy=%b fwd=%0d lat=%0d d=%h want 1 1 4 %h",
               rdy, fl, rl, rv, {32'h0BADF00D, 2'h0});
    end
  endtask

  task automatic test_random();
    bit rdy, pl, st, rr, re;
    int fl, rl, kind, rla, dla, hold, elat;
    logic [40:0] fr;
    logic [33:0] rv, dr, eresp;
    logic [6:0]  a;
    logic [1:0]  op;
    logic        unl;
    logic [31:0] d;
    for (int i = 0; i < 40; i++) begin
      a    = 7'($urandom_range(0, 127));
      op   = 2'($urandom_range(0, 3));
      unl  = 1'($urandom_range(0, 1));
      d    = $urandom;
      rla  = int'($urandom_range(0, 3));
      dla  = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 5));
      hold = int'($urandom_range(0, 3));
      dr   = {$urandom, 2'($urandom_range(0, 3))};
      kind = classify(a, op, unl);
      txn(a, d, op, unl, rla, dla, dr, hold, 0,
          rdy, pl, fl, fr, rl, rv, st, rr, re);
      if (kind == 1) begin
        exp_cnt = sat_inc(exp_cnt);
        exp_last = a;
      end
      if (kind == 2) begin
        elat  = (dla < 0) ? rla + 10 : rla + 3 + dla;
        eresp = (dla < 0) ? {32'h0, 2'h3} : dr;
      end else begin
        elat  = 1;
        eresp = (kind == 1) ? {32'h0, 2'h2} : 34'h0;
      end
      checks++;
      if (!rdy || rl !== elat || rv !== eresp || !st || rr) begin
        errors++;
        $display("FAIL rand_resp[%0d]: got rdy=%b lat=%0d d=%h want 1 %0d %h",
                 i, rdy, rl, rv, elat, eresp);
      end
      checks++;
      if ((kind == 2) ? (fl !== 1 || fr !== {a, d, op} || re) : (fl !== -1)) begin
        errors++;
        $display("FAIL rand_fwd[%0d]: got lat=%0d req=%h want kind=%0d req=%h",
                 i, fl, fr, kind, {a, d, op});
      end
      checks++;
      if (int'(blocked_cnt_o) !== exp_cnt) begin
        errors++;
        $display("FAIL rand_cnt[%0d]: got %0d want %0d",
                 i, blocked_cnt_o, exp_cnt);
      end
`ifdef DMI_FILTER_AUDIT_EN
      checks++;
      if (last_blocked_addr_o !== exp_last || pl !== (kind == 1)) begin
        errors++;
        $display("FAIL rand_audit[%0d]: got %h/%b want %h/%b",
                 i, last_blocked_addr_o, pl, exp_last, kind == 1);
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk_i);
    resp_ready_i   = 1'b0;
    dm_req_ready_i = 1'b0;
    req_i          = {7'h30, 32'h1, 2'd1};
    unlock_i       = 1'b1;
    req_valid_i    = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    checks++;
    if (dm_req_valid_o !== 1'b1) begin
      errors++; $display("FAIL mid_fwd: got %b want 1", dm_req_valid_o);
    end
    #2 rst_ni = 1'b0;
    #1;
    exp_cnt = 0;
    exp_last = '0;
    checks++;
    if (dm_req_valid_o !== 1'b0 || blocked_cnt_o !== '0 ||
        req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got dmv=%b cnt=%0d rdy=%b rv=%b want 0 0 1 0",
               dm_req_valid_o, blocked_cnt_o, req_ready_o, resp_valid_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_saturate();
    bit rdy, pl, st, rr, re;
    int fl, rl;
    logic [40:0] fr;
    logic [33:0] rv;
    for (int i = 0; i < 4; i++) begin
      txn(7'h10 + 7'(i), 32'h0, 2'd3, 1'b1, 0, 0, 34'h0, 0, 0,
          rdy, pl, fl, fr, rl, rv, st, rr, re);
      exp_cnt = sat_inc(exp_cnt);
      checks++;
      if (int'(blocked_cnt_o) !== exp_cnt || rv !== {32'h0, 2'h2}) begin
        errors++;
        $display("FAIL saturate[%0d]: got cnt=%0d d=%h want %0d %h",
                 i, blocked_cnt_o, rv, exp_cnt, {32'h0, 2'h2});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni          = 1'b0;
    unlock_i        = 1'b0;
    req_i           = '0;
    req_valid_i     = 1'b0;
    resp_ready_i    = 1'b0;
    dm_req_ready_i  = 1'b0;
    dm_resp_i       = '0;
    dm_resp_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    test_reset();
    test_locked_read();
    test_locked_write();
    test_unlock_drop();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_saturate();
    @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmi_access_filter.md
Name: dmi_access_filter

Overview:
- Core-clock stage directly downstream of the JTAG DMI front-end's clock-domain crossing. Sits between the CDC core-side DMI port and the debug module.
- Checks every DMI request against the already-synchronised unlock status and a protected address window.
- Forwards allowed requests to the debug module and answers rejected, NOP or timed-out requests locally.
- Keeps one transaction outstanding and saturation-counts rejections.

Parameters:
- ProtLo, 7'h10, lowest protected DMI address (inclusive).
- ProtHi, 7'h7F, highest protected DMI address (inclusive).
- TimeoutCycles, 1024, maximum cycles spent in WAIT_RESP before a local busy response; 0 disables the timeout.
- CntWidth, 16, width of the rejection counter.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- unlock_i  in  1  password-unlock status, already synchronised to clk_i
- req_i  in  41  request: [40:34] addr, [33:2] data, [1:0] op (0 nop, 1 read, 2 write, 3 reserved)
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted this cycle when high together with req_valid_i
- resp_o  out  34  response: [33:2] data, [1:0] resp (0 ok, 2 failed, 3 busy)
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response consumed
- dm_req_o  out  41  forwarded request, same format as req_i
- dm_req_valid_o  out  1  forwarded request valid
- dm_req_ready_i  in  1  debug module accepts the request
- dm_resp_i  in  34  debug module response
- dm_resp_valid_i  in  1  debug module response valid
- dm_resp_ready_o  out  1  always 1
- blocked_cnt_o  out  CntWidth  saturating count of rejected requests

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low; the ports are clk_i and rst_ni.
- Reset values: state IDLE; req_ready_o=1; resp_valid_o=0; resp_o=0; dm_req_valid_o=0; dm_req_o=0; blocked_cnt_o=0; timeout counter=0.
- States are IDLE, FWD, WAIT_RESP and RESP. req_ready_o = (state==IDLE).
- Accept at cycle N (IDLE and req_valid_i): register req_i and sample unlock_i. Classify the request in this order:
  - op==0: next state RESP with resp_o={32'h0,2'h0}.
  - op==3: reject.
  - op is 1 or 2, addr is in [ProtLo,ProtHi], and unlock_i==0: reject.
  - Otherwise: next state FWD.
- Reject: next state RESP with resp_o={32'h0,2'h2}; blocked_cnt_o increments, saturating at all-ones.
- FWD: dm_req_valid_o=1 and dm_req_o holds the registered request from cycle N+1. dm_req_valid_o must not drop before dm_req_ready_i. When dm_req_ready_i=1, go to WAIT_RESP and clear the timeout counter.
- WAIT_RESP:
  - dm_resp_valid_i=1: capture dm_resp_i into resp_o; next state RESP, so resp_valid_o rises one cycle later.
  - Otherwise, if TimeoutCycles!=0: the counter increments each cycle. On reaching TimeoutCycles, go to RESP with resp_o={32'h0,2'h3}.
- RESP: resp_valid_o=1 and resp_o stays stable until resp_ready_i=1; then return to IDLE. The earliest next accept is the cycle after the handshake.
- Latencies:
  - Reject or NOP response: resp_valid_o at N+1.
  - Forward: dm_req_valid_o at N+1.
  - A response received in cycle M is presented at M+1.
- Stray debug-module responses: dm_resp_ready_o is tied high. A dm_resp_valid_i outside WAIT_RESP, including a late response after a timeout, is dropped silently.
- Unlock timing: unlock_i is sampled only at accept. A change of unlock_i during FWD, WAIT_RESP or RESP does not abort or alter the transaction.
- Address window: addresses outside [ProtLo,ProtHi] are always forwarded. If ProtLo>ProtHi, nothing is protected.
- Reset mid-transaction: immediately returns to reset values. Any pending debug-module response is dropped by the rule above.

Optional Feature:
- Macro: DMI_FILTER_AUDIT_EN.
- Defined: adds output last_blocked_addr_o[6:0], reset 0, updated with the addr of each rejected request. Also adds output blocked_pulse_o[0:0], a single-cycle high in the accept cycle of each rejection.
- Undefined: neither port exists and no audit registers are synthesised. All other behaviour is identical.

Test Plan:
- Locked read of 7'h04, op=1: dm_req_valid_o rises at N+1. The debug module returns {32'hCAFE0001,2'h0}; resp_o shows that value one cycle later with resp_valid_o=1.
- Locked write to 7'h20, op=2: no dm_req_valid_o. resp_o={0,2'h2} at N+1; blocked_cnt_o goes 0→1. With DMI_FILTER_AUDIT_EN, last_blocked_addr_o=7'h20.
- Unlocked write to 7'h20, data 32'h12345678: forwarded with dm_req_o equal to req_i. unlock_i dropped during WAIT_RESP; the response still returns resp 0.
- TimeoutCycles=8 and the debug module never responds: resp_o={0,2'h3} after 8 cycles in WAIT_RESP. A late dm_resp_valid_i pulse is then ignored; resp_valid_o stays 0 in IDLE.
- resp_ready_i held low 5 cycles in RESP: resp_valid_o and resp_o stay stable and req_ready_o=0. A request accepted the cycle after the handshake completes normally.
- CntWidth=2, four rejections: blocked_cnt_o reads 1,2,3,3. Asserting rst_ni low mid-FWD clears dm_req_valid_o and the count asynchronously.
